// File: rtl/opl2_pkg.sv
// Shared types and defaults for the OPL2 slot scheduler and its write queue.
package opl2_pkg;

    localparam int OP_NUM_WIDTH        = 5;
    localparam int NUM_SLOTS           = 18;
    localparam int FIFO_DEPTH_DEFAULT  = 4;
    localparam int OP_TIMEOUT_DEFAULT  = 64;

    // One register-file write; valid qualifies address/data.
    typedef struct packed {
        logic       valid;
        logic [7:0] address;
        logic [7:0] data;
    } opl2_reg_wr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/opl2_reg_wr_fifo.sv
// Small synchronous FIFO holding host register writes until the scheduler is idle.
module opl2_reg_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO still accepts a write when an entry leaves in the same cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    assign full     = (count == CNT_MAX);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/opl2_slot_scheduler.sv
// Sequences the 18 operator slots once per sample and applies queued host writes between samples.
module opl2_slot_scheduler
    import opl2_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int OP_TIMEOUT = OP_TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_clk_en,
    input  opl2_reg_wr_t            host_wr,
    output opl2_reg_wr_t            reg_wr,
    output logic                    op_start,
    output logic [OP_NUM_WIDTH-1:0] op_num,
    input  logic                    op_done,
    output logic                    sample_done,
    output logic                    busy,
    input  logic                    err_clear,
    output logic                    overflow_err,
    output logic                    overrun_err,
    output logic                    timeout_err
);

    localparam int TW = (OP_TIMEOUT > 1) ? $clog2(OP_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(OP_TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [OP_NUM_WIDTH-1:0] SLOT_LAST = OP_NUM_WIDTH'(NUM_SLOTS - 1);
    localparam logic [OP_NUM_WIDTH-1:0] SLOT_ONE  = OP_NUM_WIDTH'(1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sched_state_t             state, state_next;
    logic [OP_NUM_WIDTH-1:0]  op_num_next;
    logic [TW-1:0]            tcnt, tcnt_next;
    logic                     timeout_hit;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [15:0]   fifo_out;

    // Writes only drain while idle and not about to start a sample, so the
    // register file is stable for the whole slot sequence.
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty && !sample_clk_en;

    opl2_reg_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (host_wr.valid),
        .push_data ({host_wr.address, host_wr.data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    fifo_count_consistent: assert property (@(posedge clk) disable iff (reset)
        fifo_empty == (fifo_count == '0));

    // Next-state, slot index, timeout counter and strobe outputs.
    always_comb begin
        state_next  = state;
        op_num_next = op_num;
        tcnt_next   = tcnt;
        timeout_hit = 1'b0;
        op_start    = 1'b0;
        sample_done = 1'b0;
        busy        = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (sample_clk_en) begin
                    state_next  = ST_ISSUE;
                    op_num_next = '0;
                end
            end
            ST_ISSUE: begin
                op_start   = 1'b1;
                tcnt_next  = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (op_done || (tcnt == T_LAST)) begin
                    timeout_hit = !op_done;
                    if (op_num == SLOT_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        op_num_next = op_num + SLOT_ONE;
                        state_next  = ST_ISSUE;
                    end
                end else begin
                    tcnt_next = tcnt + T_ONE;
                end
            end
            ST_DONE: begin
                sample_done = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register with slot index and timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_num <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_next;
            op_num <= op_num_next;
            tcnt   <= tcnt_next;
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err <= 1'b0;
            overrun_err  <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (err_clear) begin
            overflow_err <= 1'b0;
            overrun_err  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (host_wr.valid && fifo_full && !fifo_pop) overflow_err <= 1'b1;
            if (sample_clk_en && (state != ST_IDLE))     overrun_err  <= 1'b1;
            if (timeout_hit)                             timeout_err  <= 1'b1;
        end
    end

    // Registered register-file write port; address/data hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_wr <= '0;
        end else begin
            reg_wr.valid <= fifo_pop;
            if (fifo_pop) begin
                reg_wr.address <= fifo_out[15:8];
                reg_wr.data    <= fifo_out[7:0];
            end
        end
    end

endmodule

// File: doc/opl2_slot_scheduler.md
OPL2_SLOT_SCHEDULER -- requirements
Module: opl2_slot_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: host write queue depth, power of two, minimum 2.
REQ-002 Parameter OP_TIMEOUT, default 64: maximum WAIT cycles allowed per operator before forced advance.
REQ-003 clk  in  1  master clock; one clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 sample_clk_en  in  1  one-cycle pulse per sample period (every CLK_DIV_COUNT clocks).
REQ-006 host_wr  in  opl2_reg_wr_t  host register write request; valid-qualified, no backpressure.
REQ-007 reg_wr  out  opl2_reg_wr_t  write applied to the register file; valid is a one-cycle pulse.
REQ-008 op_start  out  1  one-cycle pulse launching the shared operator pipeline on op_num.
REQ-009 op_num  out  OP_NUM_WIDTH  operator slot index 0..17.
REQ-010 op_done  in  1  pipeline completion pulse for the current slot.
REQ-011 sample_done  out  1  one-cycle pulse after slot 17 completes.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 err_clear  in  1  clears all sticky error flags.
REQ-014 overflow_err, overrun_err, timeout_err  out  1 each  sticky error flags.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE: on sample_clk_en go to ISSUE with op_num=0; op_start is high on the first cycle after the pulse.
REQ-017 ISSUE lasts exactly one cycle with op_start=1, then goes to WAIT; op_done during ISSUE is ignored.
REQ-018 WAIT with op_done=1: if op_num=17 go to DONE; otherwise increment op_num and go to ISSUE.
REQ-019 WAIT timeout counter starts at 0 on WAIT entry; at count OP_TIMEOUT-1 with no op_done, set timeout_err and advance exactly as for op_done.
REQ-020 DONE lasts one cycle with sample_done=1, then returns to IDLE; op_num holds 17 until the next sample.
REQ-021 sample_clk_en in any state other than IDLE sets overrun_err and is otherwise ignored; no slot is restarted.
REQ-022 host_wr.valid pushes {address,data} into the FIFO in every state.
REQ-023 Push when FIFO is full and there is no pop in the same cycle: drop the write and set overflow_err.
REQ-024 Push when FIFO is full with a simultaneous pop: accept the write.
REQ-025 Pop occurs only in IDLE, only when the FIFO is non-empty, and only when sample_clk_en=0, at one entry per cycle.
REQ-026 Register-file writes therefore never change mid-sample.
REQ-027 reg_wr is registered: valid=1 on the cycle after the pop; address and data hold their last values while valid=0.
REQ-028 A push into an empty FIFO while in IDLE appears on reg_wr 2 cycles later.
REQ-029 FIFO order is strict first-in, first-out; pointers wrap modulo FIFO_DEPTH; the occupancy counter has width clog2(FIFO_DEPTH)+1.
REQ-030 err_clear takes priority over a same-cycle error set, so the flag reads 0 on the next cycle.

Reset
REQ-031 Reset state: IDLE, op_num=0, FIFO empty, timeout counter=0, all error flags=0.
REQ-032 Reset values: reg_wr all 0, op_start=0, sample_done=0, busy=0.
REQ-033 Reset asserted mid-sample aborts the sample immediately; no sample_done is produced and queued writes are discarded.

Structure
REQ-034 FIFO_DEPTH and OP_TIMEOUT defaults, the state enum, and the reuse of opl2_reg_wr_t and OP_NUM_WIDTH belong in opl2_pkg.
REQ-035 The FIFO is one sub-module, opl2_reg_wr_fifo, with push, pop, full, empty and count ports; the FSM and timeout counter live in the top module.

Verification
REQ-036 Bench SHALL cover:
- sample_clk_en; op_done returned 3 cycles after each op_start -> op_num steps 0..17, 18 op_start pulses, one sample_done, busy low again, no errors.
- Host writes (0x20,0x01),(0xA0,0x44) issued mid-sample -> no reg_wr until after sample_done, then both appear in order on consecutive cycles.
- Five writes in 5 consecutive busy cycles with FIFO_DEPTH=4 -> overflow_err=1, first four applied, fifth lost; err_clear -> flag 0.
- op_done withheld on slot 5 -> timeout_err set after 64 WAIT cycles, op_start for slot 6 follows, sample completes.
- Second sample_clk_en while busy -> overrun_err=1, sequence unaffected, exactly one sample_done.
- Reset asserted during slot 9 with 2 writes queued -> outputs at reset values, no sample_done, no reg_wr pulse after release.
